// File: rtl/cla_add_arbiter.sv
// Round-robin front end that shares one pipelined 32-bit adder among N_REQ requesters.
// Optional macro CLA_ARB_OVF_EN adds signed-overflow tracking on rsp_ovf.
module cla_add_arbiter #(
    parameter int N_REQ      = 4,
    parameter int ADD_LAT    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [32*N_REQ-1:0]      req_a,
    input  logic [32*N_REQ-1:0]      req_b,
    input  logic [N_REQ-1:0]         req_cin,
    output logic [31:0]              add_a,
    output logic [31:0]              add_b,
    output logic                     add_cin,
    input  logic [31:0]              add_s,
    input  logic                     add_cout,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(N_REQ)-1:0] rsp_id,
    output logic [31:0]              rsp_sum,
    output logic                     rsp_cout,
    output logic                     rsp_ovf
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

    logic [ID_W-1:0]  ptr_reg;
    logic [OCC_W-1:0] occ_reg;
    logic [ID_W-1:0]  grant_id;
    logic             grant_found;
    logic [ID_W:0]    scan_sum;
    logic [ID_W-1:0]  scan_id;
    logic             full;
    logic             accept;
    logic             pop;
    logic [31:0]      sel_a;
    logic [31:0]      sel_b;
    logic             sel_cin;

    // Scan upward from the pointer, wrapping at N_REQ (which need not be a power of two).
    always_comb begin
        grant_id    = '0;
        grant_found = 1'b0;
        scan_sum    = '0;
        scan_id     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_sum = {1'b0, ptr_reg} + (ID_W+1)'(k);
            if (scan_sum >= (ID_W+1)'(N_REQ)) begin
                scan_sum = scan_sum - (ID_W+1)'(N_REQ);
            end
            scan_id = scan_sum[ID_W-1:0];
            if (!grant_found && req_valid[scan_id]) begin
                grant_found = 1'b1;
                grant_id    = scan_id;
            end
        end
    end

    assign full = (occ_reg == OCC_W'(FIFO_DEPTH));

    always_comb begin
        req_ready = '0;
        if (!rst && !full && grant_found) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign accept  = |req_ready;
    assign pop     = rsp_valid & rsp_ready;
    assign sel_a   = req_a[32*grant_id +: 32];
    assign sel_b   = req_b[32*grant_id +: 32];
    assign sel_cin = req_cin[grant_id];

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= '0;
            occ_reg <= '0;
            add_a   <= '0;
            add_b   <= '0;
            add_cin <= 1'b0;
        end else begin
            if (accept) begin
                add_a   <= sel_a;
                add_b   <= sel_b;
                add_cin <= sel_cin;
                ptr_reg <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
            end
            case ({accept, pop})
                2'b10:   occ_reg <= occ_reg + 1'b1;
                2'b01:   occ_reg <= occ_reg - 1'b1;
                default: occ_reg <= occ_reg;
            endcase
        end
    end

    // Tag pipeline: stage 0 lines up with add_a/add_b, the tail with add_s.
    genvar gi;
    generate
        for (gi = 0; gi <= ADD_LAT; gi++) begin : g_tag
            logic            valid_reg;
            logic [ID_W-1:0] id_reg;
`ifdef CLA_ARB_OVF_EN
            logic            sa_reg;
            logic            sb_reg;
`endif
            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (rst) valid_reg <= 1'b0;
                    else     valid_reg <= accept;
                    id_reg <= grant_id;
`ifdef CLA_ARB_OVF_EN
                    sa_reg <= sel_a[31];
                    sb_reg <= sel_b[31];
`endif
                end
            end else begin : g_shift
                always_ff @(posedge clk) begin
                    if (rst) valid_reg <= 1'b0;
                    else     valid_reg <= g_tag[gi-1].valid_reg;
                    id_reg <= g_tag[gi-1].id_reg;
`ifdef CLA_ARB_OVF_EN
                    sa_reg <= g_tag[gi-1].sa_reg;
                    sb_reg <= g_tag[gi-1].sb_reg;
`endif
                end
            end
        end
    endgenerate

    logic            capture;
    logic [ID_W-1:0] tail_id;
    assign capture = g_tag[ADD_LAT].valid_reg;
    assign tail_id = g_tag[ADD_LAT].id_reg;

    logic [ID_W-1:0]  fifo_id_mem   [FIFO_DEPTH];
    logic [31:0]      fifo_sum_mem  [FIFO_DEPTH];
    logic             fifo_cout_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [OCC_W-1:0] fifo_cnt_reg;

`ifdef CLA_ARB_OVF_EN
    logic fifo_ovf_mem [FIFO_DEPTH];
    logic cap_ovf;
    assign cap_ovf = (g_tag[ADD_LAT].sa_reg == g_tag[ADD_LAT].sb_reg)
                   & (add_s[31] != g_tag[ADD_LAT].sa_reg);
`endif

    always_ff @(posedge clk) begin
        if (capture) begin
            fifo_id_mem[wr_ptr_reg]   <= tail_id;
            fifo_sum_mem[wr_ptr_reg]  <= add_s;
            fifo_cout_mem[wr_ptr_reg] <= add_cout;
`ifdef CLA_ARB_OVF_EN
            fifo_ovf_mem[wr_ptr_reg]  <= cap_ovf;
`endif
        end
    end

    // Occupancy already counts in-flight ops, so capture never finds the FIFO full.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            fifo_cnt_reg <= '0;
        end else begin
            if (capture) begin
                wr_ptr_reg <= (wr_ptr_reg == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= (rd_ptr_reg == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
            end
            case ({capture, pop})
                2'b10:   fifo_cnt_reg <= fifo_cnt_reg + 1'b1;
                2'b01:   fifo_cnt_reg <= fifo_cnt_reg - 1'b1;
                default: fifo_cnt_reg <= fifo_cnt_reg;
            endcase
        end
    end

    // Head fields read as zero whenever the FIFO is empty, including after reset.
    assign rsp_valid = (fifo_cnt_reg != '0);
    assign rsp_id    = rsp_valid ? fifo_id_mem[rd_ptr_reg]   : '0;
    assign rsp_sum   = rsp_valid ? fifo_sum_mem[rd_ptr_reg]  : '0;
    assign rsp_cout  = rsp_valid ? fifo_cout_mem[rd_ptr_reg] : 1'b0;
`ifdef CLA_ARB_OVF_EN
    assign rsp_ovf   = rsp_valid ? fifo_ovf_mem[rd_ptr_reg]  : 1'b0;
`else
    assign rsp_ovf   = 1'b0;
`endif
endmodule

// File: tb/tb_cla_add_arbiter.sv
// Bench for cla_add_arbiter: directed vector table, hand sequences and a random run
// checked against a queue-based model of grants, occupancy and response ordering.
module tb_cla_add_arbiter;
    localparam int N_REQ      = 4;
    localparam int ADD_LAT    = 1;
    localparam int FIFO_DEPTH = 4;
`ifdef CLA_ARB_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [N_REQ-1:0]     req_valid = '0;
    logic [N_REQ-1:0]     req_ready;
    logic [32*N_REQ-1:0]  req_a = '0;
    logic [32*N_REQ-1:0]  req_b = '0;
    logic [N_REQ-1:0]     req_cin = '0;
    logic [31:0]          add_a, add_b, add_s;
    logic                 add_cin, add_cout;
    logic                 rsp_valid;
    logic                 rsp_ready = 1'b0;
    logic [1:0]           rsp_id;
    logic [31:0]          rsp_sum;
    logic                 rsp_cout, rsp_ovf;

    cla_add_arbiter #(.N_REQ(N_REQ), .ADD_LAT(ADD_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_s(add_s), .add_cout(add_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf)
    );

    always #5 clk = ~clk;

    // Shared adder: ADD_LAT register stages from add_a/add_b/add_cin to add_s/add_cout.
    logic [32:0] add_pipe [ADD_LAT];
    always @(posedge clk) begin
        add_pipe[0] <= {1'b0, add_a} + {1'b0, add_b} + {32'b0, add_cin};
        for (int i = 1; i < ADD_LAT; i++) add_pipe[i] <= add_pipe[i-1];
    end
    assign {add_cout, add_s} = add_pipe[ADD_LAT-1];

    typedef struct {
        int          id;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        int          avail;
    } exp_t;

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    int   n_chk  = 0;
    int   n_fail = 0;
    int   cycle  = 0;
    int   m_ptr  = 0;
    int   m_occ  = 0;
    exp_t q[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cycle, got, want);
        end
    endtask

    // Model: grant = first valid at/after pointer if occupancy allows; results leave in
    // accept order, ADD_LAT+2 cycles after acceptance.
    task automatic model_check();
        logic [N_REQ-1:0] exp_ready;
        logic             exp_rv;
        logic [32:0]      s;
        logic [31:0]      a, b;
        int               gid, idx;
        exp_t             e;
        exp_ready = '0;
        gid = -1;
        if (!rst && m_occ < FIFO_DEPTH) begin
            for (int k = 0; k < N_REQ; k++) begin
                idx = (m_ptr + k) % N_REQ;
                if (gid < 0 && req_valid[idx]) gid = idx;
            end
        end
        if (gid >= 0) exp_ready[gid] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        exp_rv = (q.size() > 0) && (q[0].avail <= cycle);
        chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
        if (exp_rv) begin
            chk("rsp_id", 64'(rsp_id), 64'(q[0].id));
            chk("rsp_sum", 64'(rsp_sum), 64'(q[0].sum));
            chk("rsp_cout", 64'(rsp_cout), 64'(q[0].cout));
            chk("rsp_ovf", 64'(rsp_ovf), 64'(q[0].ovf));
        end
        if (rst) begin
            q.delete();
            m_ptr = 0;
            m_occ = 0;
        end else begin
            if (exp_rv && rsp_ready) begin
                q.delete(0);
                m_occ--;
            end
            if (gid >= 0) begin
                a = req_a[32*gid +: 32];
                b = req_b[32*gid +: 32];
                s = {1'b0, a} + {1'b0, b} + {32'b0, req_cin[gid]};
                e.id    = gid;
                e.sum   = s[31:0];
                e.cout  = s[32];
                e.ovf   = OVF_ON && (a[31] == b[31]) && (s[31] != a[31]);
                e.avail = cycle + ADD_LAT + 2;
                q.push_back(e);
                m_occ++;
                m_ptr = (gid + 1) % N_REQ;
            end
        end
        cycle++;
    endtask

    task automatic tick();
        @(negedge clk);
        model_check();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int id, input logic [31:0] a, input logic [31:0] b, input logic cin);
        req_a[32*id +: 32] = a;
        req_b[32*id +: 32] = b;
        req_cin[id]        = cin;
    endtask

    vec_t vt[6];
    int   ids[$];
    int   n;
    int   acc;

    initial begin
        vt[0] = '{2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vt[1] = '{1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, OVF_ON};
        vt[2] = '{0, 32'h0000_FFFF, 32'h0000_0000, 1'b1, 32'h0001_0000, 1'b0, 1'b0};
        vt[3] = '{3, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, OVF_ON};
        vt[4] = '{1, 32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0, 1'b0};
        vt[5] = '{0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};

        // Reset state, with requests pending to prove req_ready stays low under rst.
        @(posedge clk);
        #1;
        req_valid = '1;
        tick();
        tick();
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_add_a", 64'(add_a), 64'(0));
        chk("rst_add_b", 64'(add_b), 64'(0));
        chk("rst_add_cin", 64'(add_cin), 64'(0));
        chk("rst_rsp_id", 64'(rsp_id), 64'(0));
        chk("rst_rsp_sum", 64'(rsp_sum), 64'(0));
        chk("rst_rsp_cout", 64'(rsp_cout), 64'(0));
        chk("rst_rsp_ovf", 64'(rsp_ovf), 64'(0));

        // Round robin from pointer 0 with all requesters active.
        rst = 1'b0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (k == 8) req_valid = '0;
            for (int r = 0; r < N_REQ; r++) set_op(r, $urandom, $urandom, 1'($urandom));
            #1;
            if (k < 8) chk("rr_grant", 64'(req_ready), 64'(N_REQ'(1) << (k % N_REQ)));
            if (rsp_valid) ids.push_back(int'(rsp_id));
            tick();
        end
        chk("rr_rsp_count", 64'(ids.size()), 64'(8));
        for (int i = 0; i < ids.size(); i++) chk("rr_rsp_order", 64'(ids[i]), 64'(i % N_REQ));

        // Directed vectors: one op at a time, checking latency and result fields.
        for (int v = 0; v < 6; v++) begin
            set_op(vt[v].id, vt[v].a, vt[v].b, vt[v].cin);
            req_valid = N_REQ'(1) << vt[v].id;
            rsp_ready = 1'b0;
            tick();
            req_valid = '0;
            n = 0;
            while (!rsp_valid && n < 10) begin
                tick();
                n++;
            end
            chk("vec_latency", 64'(n), 64'(ADD_LAT + 1));
            chk("vec_id", 64'(rsp_id), 64'(vt[v].id));
            chk("vec_sum", 64'(rsp_sum), 64'(vt[v].sum));
            chk("vec_cout", 64'(rsp_cout), 64'(vt[v].cout));
            chk("vec_ovf", 64'(rsp_ovf), 64'(vt[v].ovf));
            rsp_ready = 1'b1;
            tick();
        end

        // Backpressure: requester 0 streams into a stalled consumer.
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        set_op(0, 32'h0000_0010, 32'h0000_0020, 1'b0);
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (req_ready[0]) acc++;
            tick();
        end
        chk("bp_accepts", 64'(acc), 64'(FIFO_DEPTH));
        #1;
        chk("bp_full", 64'(req_ready), 64'(0));
        rsp_ready = 1'b1;
        #1;
        chk("bp_pop_cycle_ready", 64'(req_ready), 64'(0));
        chk("bp_pop_cycle_valid", 64'(rsp_valid), 64'(1));
        tick();
        rsp_ready = 1'b0;
        #1;
        chk("bp_refill_ready", 64'(req_ready), 64'(1));
        tick();
        #1;
        chk("bp_full_again", 64'(req_ready), 64'(0));
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 10; k++) tick();

        // Random traffic with occasional resets, fully checked by the model.
        for (int k = 0; k < 400; k++) begin
            req_valid = N_REQ'($urandom);
            for (int r = 0; r < N_REQ; r++) set_op(r, $urandom, $urandom, 1'($urandom));
            rsp_ready = ($urandom_range(3) != 0);
            rst = ($urandom_range(63) == 0);
            tick();
        end
        rst = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 10; k++) tick();

        // Reset mid-stream: three ops in flight, pointer left at 3 before the reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_valid = '1;
        for (int k = 0; k < 3; k++) tick();
        rst = 1'b1;
        req_valid = '0;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("post_rst_rsp_valid", 64'(rsp_valid), 64'(0));
            tick();
        end
        req_valid = 4'b1010;
        #1;
        chk("post_rst_grant", 64'(req_ready), 64'(4'b0010));
        tick();
        req_valid = '0;
        for (int k = 0; k < 6; k++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d got=timeout want=finish", cycle);
        $fatal(1, "watchdog expired");
    end
endmodule
